line_delay_taps: RTL and testbench

Multi-tap line delay for the ORB image pipeline. It delays a pixel stream by k·L enabled samples for k = 1..TAPS, where L is a line length loaded at run time, up to DMAX. All taps are presented in parallel, giving the vertical column that the window and descriptor stages consume. It generalises the fixed single-length delay with run-time length, multiple taps, per-tap fill tracking and flush-on-reload.

---
 rtl/line_delay_taps.sv | 86 ++++++++
 tb/tb_line_delay_taps.sv | 139 +++++++++++++
 2 files changed

// File: rtl/line_delay_taps.sv
// Multi-tap line delay: TAPS cascaded circular buffers sharing one address counter,
// presenting x[n-k*L] for k = 1..TAPS in parallel with per-tap fill tracking.
module line_delay_taps #(
  parameter int WIDTH = 8,
  parameter int DMAX  = 1024,
  parameter int AW    = 10,
  parameter int TAPS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [WIDTH-1:0]      dat_in,
  input  logic                  len_ld,
  input  logic [AW:0]           len_in,
  output logic [TAPS*WIDTH-1:0] dat_out,
  output logic [TAPS-1:0]       tap_vld,
  output logic                  len_err,
  output logic [AW:0]           line_len
);

  localparam int LW = $clog2(TAPS + 1);
  localparam logic [AW:0]   LEN_MAX    = (AW+1)'(DMAX);
  localparam logic [AW:0]   LEN_MIN    = (AW+1)'(2);
  localparam logic [LW-1:0] LINES_FULL = LW'(TAPS);

  logic [WIDTH-1:0] mem [TAPS][DMAX];
  logic [AW-1:0]    adr;
  logic [LW-1:0]    lines;
  logic             len_ok;
  logic             adv;
  logic             at_end;

  assign len_ok = (len_in >= LEN_MIN) && (len_in <= LEN_MAX);
  assign adv    = ena && !len_ld && !rst;
  // Compare in AW+1 bits so L = 2^AW does not alias to zero.
  assign at_end = ({1'b0, adr} == (line_len - 1'b1));

  // Each buffer is read before it is written, so buffer k passes its old
  // entry on to buffer k+1 in the same cycle.
  always_ff @(posedge clk) begin
    if (adv) begin
      mem[0][adr] <= dat_in;
      for (int k = 1; k < TAPS; k++) begin
        mem[k][adr] <= mem[k-1][adr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_len <= LEN_MAX;
      adr      <= '0;
      lines    <= '0;
      dat_out  <= '0;
      tap_vld  <= '0;
      len_err  <= 1'b0;
    end else begin
      len_err <= len_ld && !len_ok;
      if (len_ld) begin
        if (len_ok) begin
          line_len <= len_in;
          adr      <= '0;
          lines    <= '0;
          dat_out  <= '0;
          tap_vld  <= '0;
        end
      end else if (ena) begin
        adr <= at_end ? '0 : adr + 1'b1;
        if (at_end && (lines != LINES_FULL)) begin
          lines <= lines + 1'b1;
        end
        // Gating on the completed-line count hides stale RAM after reset or reload.
        for (int k = 0; k < TAPS; k++) begin
          if (lines > LW'(k)) begin
            dat_out[k*WIDTH +: WIDTH] <= mem[k][adr];
            tap_vld[k]                <= 1'b1;
          end else begin
            dat_out[k*WIDTH +: WIDTH] <= '0;
            tap_vld[k]                <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_line_delay_taps.sv
// Bench for line_delay_taps: cycle-stepped stimulus compared against a
// sample-history model (tap k = sample accepted k*L samples earlier).
module tb_line_delay_taps;

  localparam int WIDTH = 8;
  localparam int DMAX  = 1024;
  localparam int AW    = 10;
  localparam int TAPS  = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  ena = 1'b0;
  logic [WIDTH-1:0]      dat_in = '0;
  logic                  len_ld = 1'b0;
  logic [AW:0]           len_in = '0;
  logic [TAPS*WIDTH-1:0] dat_out;
  logic [TAPS-1:0]       tap_vld;
  logic                  len_err;
  logic [AW:0]           line_len;

  int   total  = 0;
  int   passed = 0;
  int   hist[$];
  int   m_len  = DMAX;
  logic m_err  = 1'b0;

  line_delay_taps #(.WIDTH(WIDTH), .DMAX(DMAX), .AW(AW), .TAPS(TAPS)) dut (
    .clk(clk), .rst(rst), .ena(ena), .dat_in(dat_in), .len_ld(len_ld),
    .len_in(len_in), .dat_out(dat_out), .tap_vld(tap_vld), .len_err(len_err),
    .line_len(line_len)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock: drive on the falling edge, advance the model at the rising
  // edge, compare all outputs shortly after it.
  task automatic step(input logic r, input logic e, input logic ld, input int d, input int li);
    logic [TAPS*WIDTH-1:0] exp_dat;
    logic [TAPS-1:0]       exp_vld;
    int n;
    @(negedge clk);
    rst = r; ena = e; len_ld = ld; dat_in = WIDTH'(d); len_in = (AW+1)'(li);
    @(posedge clk);
    if (r) begin
      hist.delete(); m_len = DMAX; m_err = 1'b0;
    end else if (ld) begin
      if (li >= 2 && li <= DMAX) begin
        m_len = li; hist.delete(); m_err = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end else begin
      m_err = 1'b0;
      if (e) hist.push_back(d & ((1 << WIDTH) - 1));
    end
    #1;
    exp_dat = '0;
    exp_vld = '0;
    n = hist.size() - 1;
    for (int k = 1; k <= TAPS; k++) begin
      if (hist.size() > 0 && n >= k * m_len) begin
        exp_dat[(k-1)*WIDTH +: WIDTH] = WIDTH'(hist[n - k*m_len]);
        exp_vld[k-1] = 1'b1;
      end
    end
    check("dat_out", 64'(dat_out), 64'(exp_dat));
    check("tap_vld", 64'(tap_vld), 64'(exp_vld));
    check("len_err", 64'(len_err), 64'(m_err));
    check("line_len", 64'(line_len), 64'(m_len));
  endtask

  initial begin
    int v;
    logic e;

    // reset state
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 7, 0);

    // continuous stream at L=4
    step(0, 0, 1, 0, 4);
    for (int i = 1; i <= 20; i++) begin
      step(0, 1, 0, i, 0);
      if (i == 4) check("s1_tap1_empty", 64'(dat_out[WIDTH-1:0]), 64'd0);
      if (i == 5) check("s1_tap1_first", 64'(dat_out[WIDTH-1:0]), 64'd1);
      if (i == 8) check("s1_vld_one", 64'(tap_vld), 64'b01);
      if (i == 9) check("s1_tap2_first", 64'(dat_out[2*WIDTH-1:WIDTH]), 64'd1);
    end

    // same stream with gaps in ena
    step(0, 1, 1, 0, 4);
    v = 1;
    for (int i = 0; i < 60; i++) begin
      e = 1'($urandom_range(0, 1));
      step(0, e, 0, v, 0);
      if (e) v++;
    end

    // mid-stream reload with ena in the same cycle
    step(0, 0, 1, 0, 4);
    for (int i = 1; i <= 10; i++) step(0, 1, 0, i, 0);
    step(0, 1, 1, 99, 3);
    check("s3_flush_vld", 64'(tap_vld), 64'd0);
    for (int i = 11; i <= 20; i++) step(0, 1, 0, i, 0);

    // illegal loads mixed into the stream
    step(0, 1, 1, 50, 1);
    step(0, 1, 0, 21, 0);
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 22, 0);
    step(0, 1, 1, 51, DMAX + 1);
    step(0, 1, 1, 52, 0);
    for (int i = 23; i <= 30; i++) step(0, 1, 0, i, 0);

    // full-depth line after reset with no load, three wraps
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3 * DMAX + 4; i++) step(0, 1, 0, int'($urandom_range(0, 255)), 0);
    check("s5_vld_full", 64'(tap_vld), 64'b11);

    // reset while full, then refill at L=4
    step(1, 1, 0, 200, 0);
    check("s6_rst_vld", 64'(tap_vld), 64'd0);
    step(0, 0, 1, 0, 4);
    for (int i = 1; i <= 12; i++) begin
      step(0, 1, 0, i, 0);
      if (i == 4) check("s6_no_stale", 64'(dat_out), 64'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
